kernel_loader: RTL

Write-side sequencer for the kernel memory. Accepts 32-bit kernel coefficients over a valid/ready stream, packs them four per 128-bit word, and issues write beats on the kernel memory's `Data_In`/`Write_En`/`En`/`Last_Address` port. The final, possibly partial, beat is flagged by driving `Last_Address` low. It sits between the host/DMA coefficient stream and the kernel memory, ahead of the convolution datapath.

---
 rtl/kernel_loader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/kernel_loader.sv
// Kernel memory write sequencer: packs 32-bit coefficients four per 128-bit beat.
// Optional readback verification is enabled with `define KERNEL_LOADER_CHECK_EN.
module kernel_loader #(
   parameter int DATA_WIDTH    = 128,
   parameter int DATA_WIDTH2   = 32,
   parameter int ADDRESS_WIDTH = 6,
   parameter int KERNEL_SIZE   = 9
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     Start,
   input  logic [DATA_WIDTH2-1:0]   Coef_In,
   input  logic                     Coef_Valid,
   output logic                     Coef_Ready,
   output logic                     Busy,
   output logic                     Done,
   output logic [DATA_WIDTH-1:0]    Data_In,
   output logic                     Write_En,
   output logic                     En,
   output logic                     Last_Address,
   output logic [ADDRESS_WIDTH-1:0] Address,
   input  logic [DATA_WIDTH2-1:0]   Mem_Data_out,
   output logic                     Mismatch
);

   localparam int LANES = DATA_WIDTH / DATA_WIDTH2;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CW    = ADDRESS_WIDTH + 1;
   localparam logic [CW-1:0] KS_C      = CW'(KERNEL_SIZE);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_WRITE   = 3'd2,
      S_CHECK   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [LW-1:0]           lane_q, lane_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    last_q, last_d;
   logic                    accept_s;

`ifdef KERNEL_LOADER_CHECK_EN
   localparam int SW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

   logic [CW-1:0]           chk_q, chk_d;
   logic                    mism_q, mism_d;
   logic                    cmp_fail_s;
   logic [SW-1:0]           wr_idx_s;
   logic [SW-1:0]           rd_idx_s;
   logic [DATA_WIDTH2-1:0]  shadow_q [0:(1<<SW)-1];

   assign wr_idx_s = SW'(cnt_q);
   assign rd_idx_s = SW'(chk_q - CW'(1));

   // Shadow copy of every accepted coefficient, indexed by arrival order.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         shadow_q[wr_idx_s] <= Coef_In;
      end
   end
`else
   logic unused_s;
   assign unused_s = ^Mem_Data_out;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lane_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
`ifdef KERNEL_LOADER_CHECK_EN
         chk_q   <= '0;
         mism_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         last_q  <= last_d;
`ifdef KERNEL_LOADER_CHECK_EN
         chk_q   <= chk_d;
         mism_q  <= mism_d;
`endif
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      last_d   = last_q;
      accept_s = 1'b0;
`ifdef KERNEL_LOADER_CHECK_EN
      chk_d      = chk_q;
      mism_d     = mism_q;
      cmp_fail_s = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d = S_COLLECT;
               lane_d  = '0;
               cnt_d   = '0;
               data_d  = '0;
`ifdef KERNEL_LOADER_CHECK_EN
               mism_d  = 1'b0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_COLLECT: begin
            accept_s = Coef_Valid;
            if (Coef_Valid) begin
               data_d[lane_q*DATA_WIDTH2 +: DATA_WIDTH2] = Coef_In;
               lane_d = lane_q + LW'(1);
               cnt_d  = cnt_q + CW'(1);
               if ((lane_q == LAST_LANE) || (cnt_q + CW'(1) == KS_C)) begin
                  state_d = S_WRITE;
                  last_d  = (cnt_q + CW'(1) == KS_C);
               end else begin
                  state_d = S_COLLECT;
               end
            end else begin
               state_d = S_COLLECT;
            end
         end
         S_WRITE: begin
            // The beat leaves on this cycle; the next beat starts from empty lanes.
            lane_d = '0;
            data_d = '0;
            if (cnt_q == KS_C) begin
`ifdef KERNEL_LOADER_CHECK_EN
               state_d = S_CHECK;
               chk_d   = '0;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_COLLECT;
            end
         end
`ifdef KERNEL_LOADER_CHECK_EN
         S_CHECK: begin
            // Read data lags the address by one cycle, so compare entry chk_q-1.
            chk_d = chk_q + CW'(1);
            if ((chk_q != '0) && (Mem_Data_out != shadow_q[rd_idx_s])) begin
               cmp_fail_s = 1'b1;
               mism_d     = 1'b1;
            end else begin
               cmp_fail_s = 1'b0;
            end
            if (chk_q == KS_C) begin
               state_d = S_DONE;
            end else begin
               state_d = S_CHECK;
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign Coef_Ready   = (state_q == S_COLLECT);
   assign Busy         = (state_q != S_IDLE);
   assign Done         = (state_q == S_DONE);
   assign Data_In      = data_q;
   assign Write_En     = (state_q == S_WRITE);
   assign Last_Address = (state_q == S_WRITE) && !last_q;

`ifdef KERNEL_LOADER_CHECK_EN
   assign En       = (state_q == S_WRITE) || ((state_q == S_CHECK) && (chk_q < KS_C));
   assign Address  = ((state_q == S_CHECK) && (chk_q < KS_C)) ? chk_q[ADDRESS_WIDTH-1:0]
                                                              : {ADDRESS_WIDTH{1'b0}};
   assign Mismatch = mism_q | cmp_fail_s;
`else
   assign En       = (state_q == S_WRITE);
   assign Address  = {ADDRESS_WIDTH{1'b0}};
   assign Mismatch = 1'b0;
`endif

endmodule
